disp1_tx: RTL and testbench
===========================

DISP1_TX -- requirements
Module: disp1_tx

Interface
REQ-001 Parameter: DEPTH, 4, entries per lane FIFO (power of two, 2..16).
REQ-002 Parameter: AF_THRESH, 3, occupancy at or above which almost_full_fN asserts.
REQ-003 Port: clk  input  1  single bit-rate clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: write  input  1  push data_in1 into lane-1 FIFO and data_in2 into lane-2 FIFO.
REQ-006 Port: data_in1  input  8  lane-1 parallel byte.
REQ-007 Port: data_in2  input  8  lane-2 parallel byte.
REQ-008 Port: out1  output  1  lane-1 serial bit, MSB first.
REQ-009 Port: out2  output  1  lane-2 serial bit, MSB first.
REQ-010 Port: active  output  1  high while the FSM is in ACTIVE.
REQ-011 Port: almost_full_f1  output  1  lane-1 FIFO occupancy >= AF_THRESH.
REQ-012 Port: almost_full_f2  output  1  lane-2 FIFO occupancy >= AF_THRESH.

Function
REQ-013 The block SHALL implement FSM states RESET, SYNC, ACTIVE.
REQ-014 The block SHALL keep one shared 3-bit bit counter that increments every cycle in SYNC and ACTIVE, wrapping 7->0; the edge where the counter is 7 is the byte boundary.
REQ-015 The first rising edge with reset low SHALL move RESET->SYNC, load 8'hBC into both shift registers, and clear the bit counter.
REQ-016 SYNC SHALL transmit 8'hBC twice on both lanes (16 cycles); the boundary ending the second BC SHALL move SYNC->ACTIVE.
REQ-017 At each boundary entering or in ACTIVE, each lane SHALL independently pop and load its FIFO head if its FIFO is non-empty; otherwise it SHALL load the idle byte 8'h7C.
REQ-018 Between boundaries, shift registers SHALL shift left one bit per cycle; out1/out2 SHALL equal shift-register bit 7 (registered, no combinational path from inputs).
REQ-019 Write latency: a byte pushed at edge N into an empty FIFO SHALL start at the first boundary after edge N; its MSB appears on outN the cycle after that boundary.
REQ-020 A write while a FIFO is full SHALL be dropped for that lane only; occupancy and contents are unchanged, even when a pop occurs on the same edge.
REQ-021 A write and a pop on the same edge with FIFO not full SHALL both take effect; occupancy is unchanged.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked in log2(DEPTH)+1 bits.
REQ-023 almost_full_fN SHALL be registered and reflect occupancy after the current edge.
REQ-024 active SHALL be 1 exactly while in ACTIVE.

Reset
REQ-025 Asserting reset SHALL immediately, and from any state or mid-byte, force the FSM to RESET, empty both FIFOs, clear pointers, bit counter and shift registers, and drive out1, out2, active, almost_full_f1, almost_full_f2 and (if present) ovf_f1, ovf_f2 to 0.
REQ-026 Writes while reset is high SHALL be ignored.

Configuration
REQ-027 With macro DISP1_TX_OVF_EN defined, the block SHALL add outputs ovf_f1 and ovf_f2 (1 bit each), set sticky on any dropped write to that lane and cleared only by reset.
REQ-028 Without DISP1_TX_OVF_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Release reset, no writes -> out1/out2 show 10111100 twice starting the cycle after the first edge, active rises at the second BC boundary, then 01111100 repeats.
REQ-030 In ACTIVE, single write data_in1=8'hA5, data_in2=8'h3C -> at the next boundary lane 1 sends 10100101 and lane 2 sends 00111100, then both return to 7C.
REQ-031 Five back-to-back writes with DEPTH=4 during SYNC -> almost_full rises after the third write, the fifth write is dropped, the four bytes go out in order, ovf_fN=1 with DISP1_TX_OVF_EN.
REQ-032 FIFO full, write on a boundary pop edge -> write dropped, occupancy goes 4->3.
REQ-033 Assert reset mid-byte in ACTIVE with 2 entries queued -> all outputs 0 asynchronously; after release the link restarts with two BC bytes and no old data is sent.

Source files
------------

// File: rtl/disp1_tx.sv
// disp1_tx -- two-lane serial transmitter with per-lane byte FIFOs.
//
// After reset the link sends the sync byte 8'hBC twice on both lanes, then
// enters ACTIVE. At every byte boundary in ACTIVE, each lane sends its FIFO
// head if one is queued, otherwise the idle byte 8'h7C. Bits go out MSB first,
// one per clock, straight from the shift register flops.
//
// Optional feature: define DISP1_TX_OVF_EN to add the sticky overflow flags
// ovf_f1/ovf_f2. They set on a write dropped because that lane's FIFO is full.
//
// Ports:
//   clk                     bit-rate clock, rising edge
//   reset                   asynchronous active-high reset
//   write                   push data_in1 / data_in2 into the lane FIFOs
//   data_in1, data_in2      parallel bytes for lane 1 / lane 2
//   out1, out2              serial bits, MSB first, registered
//   active                  high while the FSM is in ACTIVE
//   almost_full_f1/_f2      registered: occupancy >= AF_THRESH
//   ovf_f1, ovf_f2          (DISP1_TX_OVF_EN only) sticky dropped-write flags
module disp1_tx #(
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    output logic       out1,
    output logic       out2,
    output logic       active,
    output logic       almost_full_f1,
    output logic       almost_full_f2
`ifdef DISP1_TX_OVF_EN
    ,
    output logic       ovf_f1,
    output logic       ovf_f2
`endif
);

    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [7:0]      SYNC_BYTE = 8'hBC;
    localparam logic [7:0]      IDLE_BYTE = 8'h7C;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sync_two_q, sync_two_d;   // second sync byte is on the wire
    logic       active_q, active_d;

    logic       boundary;
    logic       load_fifo;

    // The edge where the counter reads 7 ends a byte. Boundaries in ACTIVE,
    // and the one ending the second sync byte, load FIFO/idle data.
    assign boundary  = (state_q != ST_RESET) && (bit_cnt_q == 3'd7);
    assign load_fifo = boundary && ((state_q == ST_ACTIVE) || sync_two_q);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_two_d = sync_two_q;
        case (state_q)
            ST_RESET: begin
                state_d    = ST_SYNC;
                bit_cnt_d  = 3'd0;
                sync_two_d = 1'b0;
            end
            ST_SYNC: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (sync_two_q) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        sync_two_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
        active_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            bit_cnt_q  <= 3'd0;
            sync_two_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_two_q <= sync_two_d;
            active_q   <= active_d;
        end
    end

    logic [1:0][7:0] din;
    logic [1:0]      ser_bit;
    logic [1:0]      af_bit;
`ifdef DISP1_TX_OVF_EN
    logic [1:0]      ovf_bit;
`endif

    assign din = {data_in2, data_in1};

    for (genvar gi = 0; gi < 2; gi++) begin : gen_lane
        logic [7:0]       mem_q [DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic [7:0]       sr_q, sr_d;
        logic             af_q, af_d;
        logic             wr_en;
        logic             pop;

        // A full FIFO drops the write even if a pop frees a slot this edge.
        always_comb begin
            wr_en    = write && (count_q != FULL_CNT);
            pop      = load_fifo && (count_q != '0);
            wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
            af_d     = (count_d >= AF_CNT);
            if (state_q == ST_RESET) begin
                sr_d = SYNC_BYTE;
            end else if (boundary) begin
                if (load_fifo) begin
                    sr_d = pop ? mem_q[rd_ptr_q] : IDLE_BYTE;
                end else begin
                    sr_d = SYNC_BYTE;
                end
            end else begin
                sr_d = {sr_q[6:0], 1'b0};
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                sr_q     <= '0;
                af_q     <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                sr_q     <= sr_d;
                af_q     <= af_d;
            end
        end

        // Storage has no reset; emptiness lives entirely in the pointers/count.
        always_ff @(posedge clk) begin
            if (wr_en && !reset) begin
                mem_q[wr_ptr_q] <= din[gi];
            end
        end

        assign ser_bit[gi] = sr_q[7];
        assign af_bit[gi]  = af_q;

`ifdef DISP1_TX_OVF_EN
        logic ovf_q, ovf_d;

        always_comb begin
            ovf_d = ovf_q | (write && !wr_en);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_d;
            end
        end

        assign ovf_bit[gi] = ovf_q;
`endif
    end

    assign out1           = ser_bit[0];
    assign out2           = ser_bit[1];
    assign active         = active_q;
    assign almost_full_f1 = af_bit[0];
    assign almost_full_f2 = af_bit[1];
`ifdef DISP1_TX_OVF_EN
    assign ovf_f1         = ovf_bit[0];
    assign ovf_f2         = ovf_bit[1];
`endif

endmodule

// File: tb/tb_disp1_tx.sv
// Bench for disp1_tx (DEPTH=4, AF_THRESH=3). The stimulus pushes the expected
// byte pair for every byte slot into a queue; the monitor deserialises out1/out2
// (plus active at each byte's first bit) and compares against the queue.
module tb_disp1_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic [7:0] d2 = 8'h00;
    logic       out1, out2, active, af1, af2;
`ifdef DISP1_TX_OVF_EN
    logic       ovf1, ovf2;
`endif

    disp1_tx #(.DEPTH(4), .AF_THRESH(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .write          (write),
        .data_in1       (d1),
        .data_in2       (d2),
        .out1           (out1),
        .out2           (out2),
        .active         (active),
        .almost_full_f1 (af1),
        .almost_full_f2 (af2)
`ifdef DISP1_TX_OVF_EN
        ,
        .ovf_f1         (ovf1),
        .ovf_f2         (ovf2)
`endif
    );

    always #5 clk = ~clk;

    // Edge number since reset release: edge 1 is RESET->SYNC.
    int ec = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) ec <= 0;
        else       ec <= ec + 1;
    end

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
        logic       act;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input logic [7:0] b1, input logic [7:0] b2, input logic act, input int n);
        exp_t e;
        e.b1  = b1;
        e.b2  = b2;
        e.act = act;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act_v, input logic [7:0] req_v);
        checks++;
        if (act_v !== req_v) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act_v, req_v);
        end else begin
            $display("ok   %s value=%02h", name, act_v);
        end
    endtask

    // Return at a point between edge n-1 and edge n.
    task automatic at_edge(input int n);
        while (ec < n - 1) @(negedge clk);
    endtask

    // Return at a point after edge n, before edge n+1.
    task automatic after_edge(input int n);
        at_edge(n + 1);
    endtask

    task automatic write_at(input int n, input logic [7:0] a, input logic [7:0] b);
        at_edge(n);
        write = 1'b1;
        d1    = a;
        d2    = b;
        @(posedge clk);
        #1 write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        write = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        #1 reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual_left=%0d required_left=0", name, exp_q.size());
        end
    endtask

    // Monitor: first negedge with reset low holds bit 7 of the first sync byte.
    initial begin : monitor
        int         nb;
        int         slot;
        logic [7:0] s1, s2;
        logic       a0;
        exp_t       e;
        nb   = 0;
        slot = 0;
        s1   = 8'h00;
        s2   = 8'h00;
        a0   = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                nb = 0;
            end else begin
                if (nb == 0) a0 = active;
                s1 = {s1[6:0], out1};
                s2 = {s2[6:0], out2};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (s1 !== e.b1 || s2 !== e.b2 || a0 !== e.act) begin
                            failures++;
                            $display("FAIL byte slot=%0d lane1=%02h req=%02h lane2=%02h req=%02h active=%0b req=%0b",
                                     slot, s1, e.b1, s2, e.b2, a0, e.act);
                        end else begin
                            $display("ok   byte slot=%0d lane1=%02h lane2=%02h active=%0b", slot, s1, s2, a0);
                        end
                        slot++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state, with a write attempted while reset is high.
        repeat (3) @(negedge clk);
        write = 1'b1;
        d1    = 8'hFF;
        d2    = 8'hEE;
        @(negedge clk);
        #1 chk("reset_outputs", {3'b000, out1, out2, active, af1, af2}, 8'h00);
`ifdef DISP1_TX_OVF_EN
        chk("reset_ovf", {6'b0, ovf1, ovf2}, 8'h00);
`endif
        write = 1'b0;
        reset = 1'b0;

        // S1: two sync bytes, ACTIVE at the second boundary, then idle.
        push(8'hBC, 8'hBC, 1'b0, 2);
        push(8'h7C, 8'h7C, 1'b1, 3);
        #1 chk("release_outputs", {4'b0000, out1, out2, active, af1}, 8'h00);
        after_edge(16);
        chk("active_e16", {7'b0, active}, 8'h00);
        after_edge(17);
        chk("active_e17", {7'b0, active}, 8'h01);
        drain("s1");

        // S2: single write in ACTIVE goes out at the next boundary.
        do_reset();
        push(8'hBC, 8'hBC, 1'b0, 2);
        push(8'h7C, 8'h7C, 1'b1, 1);
        push(8'hA5, 8'h3C, 1'b1, 1);
        push(8'h7C, 8'h7C, 1'b1, 2);
        write_at(20, 8'hA5, 8'h3C);
        drain("s2");

        // S3: five back-to-back writes in SYNC; the fifth is dropped.
        do_reset();
        push(8'hBC, 8'hBC, 1'b0, 2);
        push(8'h11, 8'h81, 1'b1, 1);
        push(8'h22, 8'h82, 1'b1, 1);
        push(8'h33, 8'h83, 1'b1, 1);
        push(8'h44, 8'h84, 1'b1, 1);
        push(8'h7C, 8'h7C, 1'b1, 1);
        write_at(3, 8'h11, 8'h81);
        write_at(4, 8'h22, 8'h82);
        chk("s3_af_after2", {6'b0, af1, af2}, 8'h00);
        write_at(5, 8'h33, 8'h83);
        chk("s3_af_after3", {6'b0, af1, af2}, 8'h03);
        write_at(6, 8'h44, 8'h84);
`ifdef DISP1_TX_OVF_EN
        chk("s3_ovf_after4", {6'b0, ovf1, ovf2}, 8'h00);
`endif
        write_at(7, 8'h55, 8'h85);
        chk("s3_af_after5", {6'b0, af1, af2}, 8'h03);
`ifdef DISP1_TX_OVF_EN
        chk("s3_ovf_after5", {6'b0, ovf1, ovf2}, 8'h03);
`endif
        after_edge(17);
        chk("s3_af_occ3", {6'b0, af1, af2}, 8'h03);
        after_edge(25);
        chk("s3_af_occ2", {6'b0, af1, af2}, 8'h00);
        drain("s3");

        // S4: full FIFO, write on a pop boundary is dropped, occupancy 4->3.
        do_reset();
        push(8'hBC, 8'hBC, 1'b0, 2);
        push(8'h7C, 8'h7C, 1'b1, 1);
        push(8'hA1, 8'hB1, 1'b1, 1);
        push(8'hA2, 8'hB2, 1'b1, 1);
        push(8'hA3, 8'hB3, 1'b1, 1);
        push(8'hA4, 8'hB4, 1'b1, 1);
        push(8'h7C, 8'h7C, 1'b1, 1);
        write_at(18, 8'hA1, 8'hB1);
        write_at(19, 8'hA2, 8'hB2);
        write_at(20, 8'hA3, 8'hB3);
        write_at(21, 8'hA4, 8'hB4);
        chk("s4_af_full", {6'b0, af1, af2}, 8'h03);
`ifdef DISP1_TX_OVF_EN
        chk("s4_ovf_full", {6'b0, ovf1, ovf2}, 8'h00);
`endif
        write_at(25, 8'h5A, 8'h5B);
        chk("s4_af_occ3", {6'b0, af1, af2}, 8'h03);
`ifdef DISP1_TX_OVF_EN
        chk("s4_ovf_drop", {6'b0, ovf1, ovf2}, 8'h03);
`endif
        after_edge(33);
        chk("s4_af_occ2", {6'b0, af1, af2}, 8'h00);
        drain("s4");

        // S5: reset mid-byte in ACTIVE with two entries queued.
        do_reset();
        push(8'hBC, 8'hBC, 1'b0, 2);
        write_at(18, 8'hC1, 8'hD1);
        write_at(19, 8'hC2, 8'hD2);
        after_edge(21);
        chk("s5_pre_reset", {5'b0, out1, out2, active}, 8'h07);
        #2 reset = 1'b1;
        #1 chk("s5_async_reset", {3'b000, out1, out2, active, af1, af2}, 8'h00);
        exp_q.delete();
        @(negedge clk);
        #1 reset = 1'b0;
        push(8'hBC, 8'hBC, 1'b0, 2);
        push(8'h7C, 8'h7C, 1'b1, 3);
        drain("s5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
